// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall detection, flush/hold handling and bubble insertion.
// Optional bubble counter compiled in with `define ID_EX_BUBBLE_COUNT_EN.
`default_nettype none

module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_read_data1,
  input  logic [31:0] id_read_data2,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc_plus4,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic [3:0]  id_alu_op,
  input  logic        id_valid,
  input  logic        flush,
  input  logic        hold,
  output logic [31:0] ex_read_data1,
  output logic [31:0] ex_read_data2,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc_plus4,
  output logic [31:0] ex_rs,
  output logic [31:0] ex_rt,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_op,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_alu_src,
  output logic        ex_reg_dst,
  output logic        ex_valid,
  output logic        stall_id
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [15:0] bubble_count
`endif
);

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_dst;
    logic        valid;
  } ex_t;

  ex_t  ex_q, ex_d, id_load;
  logic pend_q, pend_d;
  logic bubble_load;

  // Side-effecting controls are squashed when the decode slot is empty.
  always_comb begin
    id_load            = '0;
    id_load.rd1        = id_read_data1;
    id_load.rd2        = id_read_data2;
    id_load.imm        = id_imm;
    id_load.pc4        = id_pc_plus4;
    id_load.rs         = id_rs;
    id_load.rt         = id_rt;
    id_load.rd         = id_rd;
    id_load.alu_op     = id_alu_op;
    id_load.reg_write  = id_reg_write & id_valid;
    id_load.mem_read   = id_mem_read & id_valid;
    id_load.mem_write  = id_mem_write & id_valid;
    id_load.mem_to_reg = id_mem_to_reg;
    id_load.alu_src    = id_alu_src;
    id_load.reg_dst    = id_reg_dst;
    id_load.valid      = id_valid;
  end

  assign stall_id = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & id_valid &
                    ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

  always_comb begin
    ex_d        = ex_q;
    pend_d      = pend_q;
    bubble_load = 1'b0;
    if (hold) begin
      pend_d = pend_q | flush;
    end else begin
      pend_d = 1'b0;
      if (flush | pend_q | stall_id) begin
        ex_d        = '0;
        bubble_load = 1'b1;
      end else begin
        ex_d = id_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      pend_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      pend_q <= pend_d;
    end
  end

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bcnt_q, bcnt_d;

  always_comb begin
    bcnt_d = bcnt_q;
    if (bubble_load && (bcnt_q != 16'hFFFF))
      bcnt_d = bcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bcnt_q <= 16'd0;
    else     bcnt_q <= bcnt_d;
  end

  assign bubble_count = bcnt_q;
`endif

  assign ex_read_data1 = ex_q.rd1;
  assign ex_read_data2 = ex_q.rd2;
  assign ex_imm        = ex_q.imm;
  assign ex_pc_plus4   = ex_q.pc4;
  assign ex_rs         = {27'd0, ex_q.rs};
  assign ex_rt         = {27'd0, ex_q.rt};
  assign ex_rd         = ex_q.rd;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_valid      = ex_q.valid;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: stimulus pushes model predictions, a monitor pops and compares.
`default_nettype none

module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_read_data1 = '0, id_read_data2 = '0, id_imm = '0, id_pc_plus4 = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic        id_mem_to_reg = 1'b0, id_alu_src = 1'b0, id_reg_dst = 1'b0;
  logic [3:0]  id_alu_op = '0;
  logic        id_valid = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [31:0] ex_read_data1, ex_read_data2, ex_imm, ex_pc_plus4, ex_rs, ex_rt;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic        ex_valid, stall_id;
`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bubble_count;
`endif

  id_ex_reg dut (
    .clk(clk), .rst(rst),
    .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm(id_imm), .id_pc_plus4(id_pc_plus4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_op(id_alu_op), .id_valid(id_valid), .flush(flush), .hold(hold),
    .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_imm(ex_imm), .ex_pc_plus4(ex_pc_plus4), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_valid(ex_valid), .stall_id(stall_id)
`ifdef ID_EX_BUBBLE_COUNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc4, rs, rt;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        rw, mr, mw, m2r, as, rdst, valid;
  } st_t;

  typedef struct packed {
    logic [31:0] d1, d2, imm, pc;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  op;
    logic        rw, mr, mw, m2r, as, rdst, valid, flush, hold, rst;
  } in_t;

  typedef struct {
    st_t  cur;
    logic stall;
    st_t  nxt;
    int   cnt_cur;
    int   cnt_nxt;
  } rec_t;

  rec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  in_t  nx;
  st_t  m;
  bit   m_pend;
  int   m_cnt;

  function automatic st_t dut_st();
    st_t s;
    s.rd1 = ex_read_data1;  s.rd2 = ex_read_data2;  s.imm = ex_imm;  s.pc4 = ex_pc_plus4;
    s.rs = ex_rs;  s.rt = ex_rt;  s.rd = ex_rd;  s.op = ex_alu_op;
    s.rw = ex_reg_write;  s.mr = ex_mem_read;  s.mw = ex_mem_write;
    s.m2r = ex_mem_to_reg;  s.as = ex_alu_src;  s.rdst = ex_reg_dst;  s.valid = ex_valid;
    return s;
  endfunction

  task automatic chk_st(input string nm, input st_t a, input st_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  task automatic chk_val(input string nm, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge and predict the outcome.
  task automatic step();
    rec_t r;
    logic stall;
    @(negedge clk);
    rst = nx.rst;  id_read_data1 = nx.d1;  id_read_data2 = nx.d2;  id_imm = nx.imm;
    id_pc_plus4 = nx.pc;  id_rs = nx.rs;  id_rt = nx.rt;  id_rd = nx.rd;  id_alu_op = nx.op;
    id_reg_write = nx.rw;  id_mem_read = nx.mr;  id_mem_write = nx.mw;
    id_mem_to_reg = nx.m2r;  id_alu_src = nx.as;  id_reg_dst = nx.rdst;
    id_valid = nx.valid;  flush = nx.flush;  hold = nx.hold;
    #1;
    if (nx.rst) begin
      m = '0;  m_pend = 1'b0;  m_cnt = 0;
    end
    r.cur = m;
    r.cnt_cur = m_cnt;
    stall = !nx.rst && m.valid && m.mr && (m.rt != 32'd0) && nx.valid &&
            ((m.rt == {27'd0, nx.rs}) || (m.rt == {27'd0, nx.rt}));
    r.stall = stall;
    if (nx.rst) begin
      // state stays empty while reset is held through the edge
    end else if (nx.hold) begin
      m_pend = m_pend || nx.flush;
    end else if (nx.flush || m_pend || stall) begin
      m = '0;
      m_pend = 1'b0;
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_pend = 1'b0;
      m.rd1 = nx.d1;  m.rd2 = nx.d2;  m.imm = nx.imm;  m.pc4 = nx.pc;
      m.rs = {27'd0, nx.rs};  m.rt = {27'd0, nx.rt};  m.rd = nx.rd;  m.op = nx.op;
      m.rw = nx.rw && nx.valid;  m.mr = nx.mr && nx.valid;  m.mw = nx.mw && nx.valid;
      m.m2r = nx.m2r;  m.as = nx.as;  m.rdst = nx.rdst;  m.valid = nx.valid;
    end
    r.nxt = m;
    r.cnt_nxt = m_cnt;
    sb.push_back(r);
  endtask

  task automatic rand_nx();
    nx.d1 = $urandom;  nx.d2 = $urandom;  nx.imm = $urandom;  nx.pc = $urandom;
    nx.rs = 5'($urandom_range(0, 7));
    nx.rt = 5'($urandom_range(0, 7));
    nx.rd = 5'($urandom_range(0, 31));
    nx.op = 4'($urandom_range(0, 15));
    nx.rw = 1'($urandom_range(0, 1));
    nx.mr = ($urandom_range(0, 2) == 0);
    nx.mw = 1'($urandom_range(0, 1));
    nx.m2r = 1'($urandom_range(0, 1));
    nx.as = 1'($urandom_range(0, 1));
    nx.rdst = 1'($urandom_range(0, 1));
    nx.valid = ($urandom_range(0, 9) != 0);
    nx.flush = ($urandom_range(0, 9) == 0);
    nx.hold = ($urandom_range(0, 6) == 0);
    nx.rst = ($urandom_range(0, 49) == 0);
  endtask

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        r = sb[0];
        chk_st("pre_edge_state", dut_st(), r.cur);
        chk_val("stall_id", {15'd0, stall_id}, {15'd0, r.stall});
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk_val("bubble_count_pre", bubble_count, 16'(r.cnt_cur));
`endif
        @(posedge clk);
        #1;
        r = sb.pop_front();
        chk_st("post_edge_state", dut_st(), r.nxt);
`ifdef ID_EX_BUBBLE_COUNT_EN
        chk_val("bubble_count_post", bubble_count, 16'(r.cnt_nxt));
`endif
      end
    end
  end

  initial begin : stimulus
    m = '0;  m_pend = 1'b0;  m_cnt = 0;
    nx = '0;  nx.rst = 1'b1;
    step();
    step();
    // plain load
    nx = '0;  nx.valid = 1'b1;  nx.rs = 5'd3;  nx.rt = 5'd4;  nx.d1 = 32'h11;
    step();
    // lw into $5, then a consumer of $5, then the consumer re-presented
    nx = '0;  nx.valid = 1'b1;  nx.mr = 1'b1;  nx.rw = 1'b1;  nx.m2r = 1'b1;
    nx.rs = 5'd2;  nx.rt = 5'd5;
    step();
    nx = '0;  nx.valid = 1'b1;  nx.rs = 5'd5;  nx.rt = 5'd6;  nx.d1 = 32'hABCD;
    step();
    step();
    // lw into $0 never stalls
    nx = '0;  nx.valid = 1'b1;  nx.mr = 1'b1;  nx.rt = 5'd0;
    step();
    nx = '0;  nx.valid = 1'b1;  nx.d2 = 32'h22;
    step();
    // flush arriving under a three-cycle hold
    nx = '0;  nx.valid = 1'b1;  nx.d1 = 32'h7;  nx.rd = 5'd9;
    step();
    nx.hold = 1'b1;  nx.flush = 1'b1;  nx.d1 = 32'h8;
    step();
    nx.flush = 1'b0;
    step();
    step();
    nx.hold = 1'b0;
    step();
    step();
    // asynchronous reset while a valid instruction sits in EX
    nx = '0;  nx.valid = 1'b1;  nx.d2 = 32'hDEAD;  nx.rw = 1'b1;
    step();
    nx.rst = 1'b1;
    step();
    nx.rst = 1'b0;
    step();
    for (int i = 0; i < 600; i++) begin
      rand_nx();
      step();
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    nx = '0;  nx.rst = 1'b1;
    step();
    nx.rst = 1'b0;  nx.flush = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    nx.flush = 1'b0;  nx.hold = 1'b1;  nx.valid = 1'b1;
    step();
`endif
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have port: clk  input  1  single pipeline clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: id_read_data1, id_read_data2, id_imm, id_pc_plus4  input  32 each  decode-stage operands, sign-extended immediate, PC+4.
REQ-004 SHALL have ports: id_rs, id_rt, id_rd  input  5 each  decode-stage register indices.
REQ-005 SHALL have ports: id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decode control bits.
REQ-006 SHALL have port: id_alu_op  input  4  ALU operation code; id_valid  input  1  decode slot holds a real instruction.
REQ-007 SHALL have ports: flush  input  1  branch/jump squash of the decode slot; hold  input  1  downstream memory stall, freeze EX.
REQ-008 SHALL have outputs ex_read_data1, ex_read_data2, ex_imm, ex_pc_plus4 (32), ex_rd (5), ex_alu_op (4), ex_valid and all six ex_ control bits (1), registered copies of the id_ inputs.
REQ-009 SHALL have outputs ex_rs, ex_rt  32  register indices zero-extended to 32 bits (bits 31:5 always 0), consumed by the forwarding unit.
REQ-010 SHALL have output stall_id  1  combinational load-use stall request to PC and IF/ID register.

Function
REQ-011 SHALL compute stall_id = ex_valid & ex_mem_read & (ex_rt[4:0] != 0) & id_valid & ((ex_rt[4:0] == id_rs) | (ex_rt[4:0] == id_rt)), from registered EX state only.
REQ-012 SHALL apply per-edge priority: hold > (flush or pending flush) > stall_id > normal load.
REQ-013 SHALL on hold=1 retain every ex_ register and the bubble counter unchanged; stall_id stays as per REQ-011.
REQ-014 SHALL on flush=1 during hold set an internal pending_flush flag; flag cleared on the first edge with hold=0, that edge loads a bubble.
REQ-015 SHALL load a bubble on flush (or pending_flush) with hold=0: ex_valid=0, all ex_ control bits, ex_alu_op, data, indices =0.
REQ-016 SHALL load a bubble on stall_id=1 with hold=0 and no flush; the decode instruction is re-presented next cycle by upstream.
REQ-017 SHALL otherwise load all id_ inputs into ex_ registers with one-cycle latency; ex_valid=id_valid.
REQ-018 SHALL force ex_reg_write, ex_mem_read, ex_mem_write to 0 whenever the loaded id_valid=0.
REQ-019 SHALL guarantee stall_id lasts at most one cycle per load (bubble clears ex_mem_read), except when extended by hold.

Reset
REQ-020 SHALL on rst=1 immediately clear every ex_ output, pending_flush and the bubble counter to 0, independent of clk.
REQ-021 SHALL take reset mid-hold or mid-stall to the empty state (ex_valid=0, stall_id=0); first post-reset edge performs a normal load.

Configuration
REQ-022 SHALL compile, when macro ID_EX_BUBBLE_COUNT_EN is defined, a 16-bit output bubble_count incrementing on each bubble load (REQ-015/016), saturating at 16'hFFFF, frozen by hold.
REQ-023 SHALL, without ID_EX_BUBBLE_COUNT_EN, omit the bubble_count port and counter entirely; all other behaviour identical.

Verification
REQ-024 Normal load: id_rs=3, id_rt=4, id_read_data1=32'h11, id_valid=1 -> next edge ex_rs=32'd3, ex_rt=32'd4, ex_read_data1=32'h11, ex_valid=1.
REQ-025 Load-use: EX holds lw with ex_rt=5, ex_mem_read=1; ID presents id_rs=5 -> stall_id=1, next edge ex_valid=0, stall_id=0; ex_rt=0, bubble_count +1.
REQ-026 Load-use to $0: EX lw ex_rt=0, id_rs=0 -> stall_id=0, normal load.
REQ-027 Flush during hold: hold=1 for 3 cycles with flush=1 on cycle 1 -> ex_ regs unchanged through hold; first edge after hold=0 loads bubble, following edge loads id_ normally.
REQ-028 Async reset: assert rst between edges while ex_valid=1 -> all ex_ outputs 0 before next edge; bubble_count=0.
REQ-029 Saturation (macro defined): preload 16'hFFFE, force two bubbles -> bubble_count 16'hFFFF and stays.
